decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/isa_pkg.sv | 81 ++++++++
 rtl/decode_stage_if.sv | 41 ++++
 rtl/decode_table.sv | 71 +++++++
 rtl/decode_stage.sv | 123 ++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: ALU operation codes, run-type
// opcodes, FSM states and the decoded control word.
package isa_pkg;

  typedef enum logic [4:0] {
    ALU_AND  = 5'd0,
    ALU_XOR  = 5'd1,
    ALU_OR   = 5'd2,
    ALU_SHL  = 5'd3,
    ALU_SHR  = 5'd4,
    ALU_ADD  = 5'd5,
    ALU_SUB  = 5'd6,
    ALU_BLT  = 5'd7,
    ALU_BGT  = 5'd8,
    ALU_BEQ  = 5'd9,
    ALU_USUB = 5'd10,
    ALU_SLT  = 5'd11,
    ALU_SGT  = 5'd12,
    ALU_UADD = 5'd13,
    ALU_NOP  = 5'd31
  } alu_op_e;

  typedef enum logic [4:0] {
    OP_IMM    = 5'd0,
    OP_LOAD   = 5'd1,
    OP_STORE  = 5'd2,
    OP_ADD    = 5'd3,
    OP_SUB    = 5'd4,
    OP_XOR    = 5'd5,
    OP_OR     = 5'd6,
    OP_AND    = 5'd7,
    OP_BRANCH = 5'd8,
    OP_BEQ    = 5'd9,
    OP_BLT    = 5'd10,
    OP_BGT    = 5'd11,
    OP_SHL    = 5'd12,
    OP_SHR    = 5'd13,
    OP_USUB   = 5'd14,
    OP_SLT    = 5'd15,
    OP_SGT    = 5'd16,
    OP_UADD   = 5'd17
  } opcode_e;

  localparam int OP_MAX = 17;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef struct packed {
    logic    branch;
    logic    mem_to_reg;
    logic    mem_write;
    logic    reg_write;
    logic    put_en;
    logic    op_en;
    logic    imm_to_reg;
    logic    illegal;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    branch:     1'b0,
    mem_to_reg: 1'b0,
    mem_write:  1'b0,
    reg_write:  1'b0,
    put_en:     1'b0,
    op_en:      1'b0,
    imm_to_reg: 1'b0,
    illegal:    1'b0,
    alu_op:     ALU_NOP
  };

  // Load and store words need memory bubbles after they issue.
  function automatic logic is_mem(input ctrl_t c);
    return c.mem_to_reg | c.mem_write;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake and control-word bundle between the fetch side, the decode
// stage and the execute side.
interface decode_stage_if #(
  parameter int IW  = 9,
  parameter int PCW = 12
);

  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  instruction;
  logic [PCW-1:0] instr_ROM_ctr;

  logic           out_valid;
  logic           out_ready;
  logic           branchFlag;
  logic           memToRegFlag;
  logic           memWriteFlag;
  logic           regWriteFlag;
  logic           putEn;
  logic           opEn;
  logic           immtoRegFlag;
  logic           illegal;
  logic [4:0]     ALUOp;
  logic [IW-2:0]  value;
  logic [PCW-1:0] control_ctr;

  modport master (
    output in_valid, instruction, instr_ROM_ctr, out_ready,
    input  in_ready, out_valid, branchFlag, memToRegFlag, memWriteFlag,
           regWriteFlag, putEn, opEn, immtoRegFlag, illegal, ALUOp,
           value, control_ctr
  );

  modport slave (
    input  in_valid, instruction, instr_ROM_ctr, out_ready,
    output in_ready, out_valid, branchFlag, memToRegFlag, memWriteFlag,
           regWriteFlag, putEn, opEn, immtoRegFlag, illegal, ALUOp,
           value, control_ctr
  );

endinterface

// File: rtl/decode_table.sv
// Purely combinational map from the type bit and opcode field of an
// instruction to its control word.
module decode_table
  import isa_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW:0] fields,
  output ctrl_t        ctrl
);

  logic [OPW-1:0] opcode;

  assign opcode = fields[OPW:1];

  // Put words ignore the opcode; run words outside the table are illegal.
  always_comb begin
    ctrl = CTRL_RESET;
    if (fields[0]) begin
      ctrl.put_en = 1'b1;
    end else if (int'(opcode) > OP_MAX) begin
      ctrl.illegal = 1'b1;
    end else begin
      ctrl.op_en     = 1'b1;
      ctrl.reg_write = 1'b1;
      case (opcode_e'(5'(opcode)))
        OP_IMM:    ctrl.imm_to_reg = 1'b1;
        OP_LOAD:   ctrl.mem_to_reg = 1'b1;
        OP_STORE: begin
          ctrl.mem_write = 1'b1;
          ctrl.reg_write = 1'b0;
        end
        OP_ADD:    ctrl.alu_op = ALU_ADD;
        OP_SUB:    ctrl.alu_op = ALU_SUB;
        OP_XOR:    ctrl.alu_op = ALU_XOR;
        OP_OR:     ctrl.alu_op = ALU_OR;
        OP_AND:    ctrl.alu_op = ALU_AND;
        OP_BRANCH: begin
          ctrl.branch    = 1'b1;
          ctrl.reg_write = 1'b0;
        end
        OP_BEQ: begin
          ctrl.alu_op    = ALU_BEQ;
          ctrl.reg_write = 1'b0;
        end
        OP_BLT: begin
          ctrl.alu_op    = ALU_BLT;
          ctrl.reg_write = 1'b0;
        end
        OP_BGT: begin
          ctrl.alu_op    = ALU_BGT;
          ctrl.reg_write = 1'b0;
        end
        OP_SHL:    ctrl.alu_op = ALU_SHL;
        OP_SHR:    ctrl.alu_op = ALU_SHR;
        OP_USUB:   ctrl.alu_op = ALU_USUB;
        OP_SLT: begin
          ctrl.alu_op    = ALU_SLT;
          ctrl.reg_write = 1'b0;
        end
        OP_SGT: begin
          ctrl.alu_op    = ALU_SGT;
          ctrl.reg_write = 1'b0;
        end
        OP_UADD:   ctrl.alu_op = ALU_UADD;
        default:   ctrl = CTRL_RESET;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-deep registered issue slot in front of execute, with
// memory bubbles after load/store and suppression of repeated PCs.
module decode_stage
  import isa_pkg::*;
#(
  parameter int IW       = 9,
  parameter int OPW      = 5,
  parameter int PCW      = 12,
  parameter int MEM_WAIT = 1,
  parameter int DEDUP    = 1
) (
  input logic           clk,
  input logic           reset_n,
  decode_stage_if.slave bus
);

  localparam int            CW       = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

  state_e         state;
  state_e         state_next;
  logic [CW-1:0]  cnt;
  logic [PCW-1:0] last_pc;
  logic           last_valid;
  logic           alive;
  ctrl_t          dec;
  ctrl_t          ctrl_q;
  logic [IW-2:0]  value_q;
  logic [PCW-1:0] ctr_q;
  logic           ready;
  logic           accept;
  logic           dup;
  logic           issue;
  logic           go_wait;

  decode_table #(.OPW(OPW)) u_table (
    .fields (bus.instruction[OPW:0]),
    .ctrl   (dec)
  );

  assign dup = (DEDUP != 0) && last_valid && (bus.instr_ROM_ctr == last_pc);

  // A repeated PC is consumed but never issued, so from ISSUE it drops to IDLE.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    go_wait    = 1'b0;
    case (state)
      IDLE:    ready = alive;
      ISSUE:   ready = bus.out_ready && !is_mem(ctrl_q);
      default: ready = 1'b0;
    endcase
    accept = ready && bus.in_valid;
    issue  = accept && !dup;
    case (state)
      IDLE: begin
        if (issue) state_next = ISSUE;
      end
      ISSUE: begin
        if (bus.out_ready) begin
          if (is_mem(ctrl_q) && (MEM_WAIT > 0)) begin
            state_next = WAIT;
            go_wait    = 1'b1;
          end else if (issue) begin
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // alive holds off in_ready until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      alive      <= 1'b0;
      cnt        <= '0;
      last_pc    <= '0;
      last_valid <= 1'b0;
      ctrl_q     <= CTRL_RESET;
      value_q    <= '0;
      ctr_q      <= '0;
    end else begin
      state <= state_next;
      alive <= 1'b1;
      if (accept) begin
        last_pc    <= bus.instr_ROM_ctr;
        last_valid <= 1'b1;
      end
      if (issue) begin
        ctrl_q  <= dec;
        value_q <= bus.instruction[IW-1:1];
        ctr_q   <= bus.instr_ROM_ctr;
      end
      if (go_wait) begin
        cnt <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign bus.in_ready     = ready;
  assign bus.out_valid    = (state == ISSUE);
  assign bus.branchFlag   = ctrl_q.branch;
  assign bus.memToRegFlag = ctrl_q.mem_to_reg;
  assign bus.memWriteFlag = ctrl_q.mem_write;
  assign bus.regWriteFlag = ctrl_q.reg_write;
  assign bus.putEn        = ctrl_q.put_en;
  assign bus.opEn         = ctrl_q.op_en;
  assign bus.immtoRegFlag = ctrl_q.imm_to_reg;
  assign bus.illegal      = ctrl_q.illegal;
  assign bus.ALUOp        = ctrl_q.alu_op;
  assign bus.value        = value_q;
  assign bus.control_ctr  = ctr_q;

endmodule
